// File: rtl/csp_tree_router.sv
// csp_tree_router
//   Three-port packet router node for a binary-tree network. Each input
//   packet is steered by its MSB to one of the two other ports and is
//   forwarded unmodified through a one-entry output register on that port.
//
//   Routing (MSB=0 / MSB=1):
//     p  -> c1out / c2out
//     c1 -> pout  / c2out
//     c2 -> pout  / c1out
//
//   Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     p_*,  c1_*,  c2_*          inbound links  (data/valid in, ready out)
//     pout_*, c1out_*, c2out_*   outbound links (data/valid out, ready in)
//
//   Each output arbitrates between its two possible sources with a 1-bit
//   round-robin pointer; the first-listed source is favoured out of reset.
module csp_tree_router #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_data,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [WIDTH-1:0] c1_data,
  input  logic             c1_valid,
  output logic             c1_ready,
  input  logic [WIDTH-1:0] c2_data,
  input  logic             c2_valid,
  output logic             c2_ready,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [WIDTH-1:0] c1out_data,
  output logic             c1out_valid,
  input  logic             c1out_ready,
  output logic [WIDTH-1:0] c2out_data,
  output logic             c2out_valid,
  input  logic             c2out_ready
);

  localparam int MSB = WIDTH - 1;

  // Round-robin grant between source a (first-listed) and source b.
  // pri_b=1 means b is favoured on a tie. Returns {grant_b, grant_a}.
  function automatic logic [1:0] rr_grant(input logic req_a,
                                          input logic req_b,
                                          input logic pri_b);
    logic [1:0] g;
    g[0] = req_a & (~req_b | ~pri_b);
    g[1] = req_b & (~req_a | pri_b);
    return g;
  endfunction

  // Output registers and arbitration pointers
  logic [WIDTH-1:0] pout_d_p1, c1out_d_p1, c2out_d_p1;
  logic             pout_vld_p1, c1out_vld_p1, c2out_vld_p1;
  logic             pout_pri, c1out_pri, c2out_pri;

  // Per-input requests toward each possible target
  logic p_to_c1, p_to_c2, c1_to_p, c1_to_c2, c2_to_p, c2_to_c1;
  logic pout_ld, c1out_ld, c2out_ld;
  logic [1:0] pout_gnt, c1out_gnt, c2out_gnt;

  // Stage p0: route, arbitrate and handshake (combinational)
  always_comb begin
    p_to_c1  = p_valid  & ~p_data[MSB];
    p_to_c2  = p_valid  &  p_data[MSB];
    c1_to_p  = c1_valid & ~c1_data[MSB];
    c1_to_c2 = c1_valid &  c1_data[MSB];
    c2_to_p  = c2_valid & ~c2_data[MSB];
    c2_to_c1 = c2_valid &  c2_data[MSB];

    // An output can take a word when empty or when it drains this cycle.
    pout_ld  = ~reset & (~pout_vld_p1  | pout_ready);
    c1out_ld = ~reset & (~c1out_vld_p1 | c1out_ready);
    c2out_ld = ~reset & (~c2out_vld_p1 | c2out_ready);

    pout_gnt  = rr_grant(c1_to_p, c2_to_p,  pout_pri)  & {2{pout_ld}};
    c1out_gnt = rr_grant(p_to_c1, c2_to_c1, c1out_pri) & {2{c1out_ld}};
    c2out_gnt = rr_grant(p_to_c2, c1_to_c2, c2out_pri) & {2{c2out_ld}};

    // Each input requests exactly one output, so its ready is the OR of
    // the grants it could receive.
    p_ready  = c1out_gnt[0] | c2out_gnt[0];
    c1_ready = pout_gnt[0]  | c2out_gnt[1];
    c2_ready = pout_gnt[1]  | c1out_gnt[1];
  end

  // Stage p1: output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pout_vld_p1 <= 1'b0;
      pout_d_p1   <= '0;
      pout_pri    <= 1'b0;
    end else if (|pout_gnt) begin
      pout_vld_p1 <= 1'b1;
      pout_d_p1   <= pout_gnt[0] ? c1_data : c2_data;
      pout_pri    <= pout_gnt[0];
    end else if (pout_ready) begin
      pout_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c1out_vld_p1 <= 1'b0;
      c1out_d_p1   <= '0;
      c1out_pri    <= 1'b0;
    end else if (|c1out_gnt) begin
      c1out_vld_p1 <= 1'b1;
      c1out_d_p1   <= c1out_gnt[0] ? p_data : c2_data;
      c1out_pri    <= c1out_gnt[0];
    end else if (c1out_ready) begin
      c1out_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c2out_vld_p1 <= 1'b0;
      c2out_d_p1   <= '0;
      c2out_pri    <= 1'b0;
    end else if (|c2out_gnt) begin
      c2out_vld_p1 <= 1'b1;
      c2out_d_p1   <= c2out_gnt[0] ? p_data : c1_data;
      c2out_pri    <= c2out_gnt[0];
    end else if (c2out_ready) begin
      c2out_vld_p1 <= 1'b0;
    end
  end

  assign pout_data   = pout_d_p1;
  assign pout_valid  = pout_vld_p1;
  assign c1out_data  = c1out_d_p1;
  assign c1out_valid = c1out_vld_p1;
  assign c2out_data  = c2out_d_p1;
  assign c2out_valid = c2out_vld_p1;

endmodule

// File: tb/tb_csp_tree_router.sv
// Testbench for csp_tree_router. Port index 0=p, 1=c1, 2=c2 is used for both
// inbound links and the matching outbound links (pout, c1out, c2out).
module tb_csp_tree_router;

  logic        clk;
  logic        reset;
  logic [10:0] p_data, c1_data, c2_data;
  logic        p_valid, c1_valid, c2_valid;
  logic        p_ready, c1_ready, c2_ready;
  logic [10:0] pout_data, c1out_data, c2out_data;
  logic        pout_valid, c1out_valid, c2out_valid;
  logic        pout_ready, c1out_ready, c2out_ready;

  csp_tree_router #(.WIDTH(11)) dut (
    .clk(clk), .reset(reset),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .c1_data(c1_data), .c1_valid(c1_valid), .c1_ready(c1_ready),
    .c2_data(c2_data), .c2_valid(c2_valid), .c2_ready(c2_ready),
    .pout_data(pout_data), .pout_valid(pout_valid), .pout_ready(pout_ready),
    .c1out_data(c1out_data), .c1out_valid(c1out_valid), .c1out_ready(c1out_ready),
    .c2out_data(c2out_data), .c2out_valid(c2out_valid), .c2out_ready(c2out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus-owned state
  logic [10:0] src_q [3][$];
  logic [10:0] lit_q [3][$];
  bit          done;

  // Checker-owned state
  int          checks;
  int          errors;
  int          cyc;
  int          lit_idx [3];
  logic        mvld [3];
  logic [10:0] mdat [3];
  int          mlast [3];

  function automatic string oname(input int o);
    return (o == 0) ? "pout" : (o == 1) ? "c1out" : "c2out";
  endfunction

  function automatic string iname(input int i);
    return (i == 0) ? "p" : (i == 1) ? "c1" : "c2";
  endfunction

  // Output a packet from input i with routing bit msb is sent to.
  function automatic int tgt(input int i, input logic msb);
    if (i == 0) return msb ? 2 : 1;
    if (i == 1) return msb ? 2 : 0;
    return msb ? 1 : 0;
  endfunction

  // The two inputs feeding output o: first-listed and second-listed.
  function automatic int lo_src(input int o);
    return (o == 0) ? 1 : 0;
  endfunction
  function automatic int hi_src(input int o);
    return (o == 2) ? 1 : 2;
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model and per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : cmp
    logic [10:0] din [3];
    logic        vin [3];
    logic        ordy [3];
    logic        dv [3];
    logic [10:0] dd [3];
    logic        dr [3];
    int          win [3];
    int          a, b;
    logic        ra, rb, expr;

    din[0] = p_data;     din[1] = c1_data;     din[2] = c2_data;
    vin[0] = p_valid;    vin[1] = c1_valid;    vin[2] = c2_valid;
    dr[0]  = p_ready;    dr[1]  = c1_ready;    dr[2]  = c2_ready;
    ordy[0] = pout_ready; ordy[1] = c1out_ready; ordy[2] = c2out_ready;
    dv[0] = pout_valid;  dv[1] = c1out_valid;  dv[2] = c2out_valid;
    dd[0] = pout_data;   dd[1] = c1out_data;   dd[2] = c2out_data;
    cyc++;

    if (reset) begin
      for (int o = 0; o < 3; o++) begin
        mvld[o] = 1'b0;
        mdat[o] = '0;
        mlast[o] = hi_src(o);
      end
    end

    for (int o = 0; o < 3; o++) begin
      check({oname(o), "_valid"}, {10'b0, dv[o]}, {10'b0, mvld[o]});
      check({oname(o), "_data"}, dd[o], mdat[o]);
    end

    for (int o = 0; o < 3; o++) begin
      a = lo_src(o);
      b = hi_src(o);
      ra = vin[a] && (tgt(a, din[a][10]) == o);
      rb = vin[b] && (tgt(b, din[b][10]) == o);
      win[o] = -1;
      if (!reset && (!mvld[o] || ordy[o])) begin
        if (ra && rb) win[o] = (mlast[o] == a) ? b : a;
        else if (ra)  win[o] = a;
        else if (rb)  win[o] = b;
      end
    end

    for (int i = 0; i < 3; i++) begin
      expr = vin[i] && (win[tgt(i, din[i][10])] == i);
      check({iname(i), "_ready"}, {10'b0, dr[i]}, {10'b0, expr});
    end

    if (!reset) begin
      for (int o = 0; o < 3; o++) begin
        if (mvld[o] && ordy[o] && (lit_idx[o] < lit_q[o].size())) begin
          check({oname(o), "_delivered"}, mdat[o], lit_q[o][lit_idx[o]]);
          lit_idx[o]++;
        end
        if (win[o] >= 0) begin
          mvld[o] = 1'b1;
          mdat[o] = din[win[o]];
          mlast[o] = win[o];
        end else if (ordy[o]) begin
          mvld[o] = 1'b0;
        end
      end
    end

    if (done || cyc > 20000) begin
      if (!done) begin
        errors++;
        $display("FAIL watchdog: got %0d cycles expected under 20000", cyc);
      end
      for (int o = 0; o < 3; o++)
        check({oname(o), "_all_delivered"}, lit_idx[o][10:0], lit_q[o].size() % 2048);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Present the head of each source queue on its link.
  task automatic present();
    p_valid  = (src_q[0].size() > 0);
    p_data   = p_valid  ? src_q[0][0] : '0;
    c1_valid = (src_q[1].size() > 0);
    c1_data  = c1_valid ? src_q[1][0] : '0;
    c2_valid = (src_q[2].size() > 0);
    c2_data  = c2_valid ? src_q[2][0] : '0;
  endtask

  // One clock: note accepted words before the edge, retire them after it.
  task automatic step();
    logic [2:0] tk;
    @(negedge clk);
    tk = {c2_valid & c2_ready, c1_valid & c1_ready, p_valid & p_ready};
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (tk[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    present();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size()) > 0 && n < 300) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic set_sinks(input logic a, input logic b, input logic c);
    pout_ready = a;
    c1out_ready = b;
    c2out_ready = c;
  endtask

  initial begin
    reset = 1'b1;
    done = 1'b0;
    set_sinks(1'b1, 1'b1, 1'b1);
    present();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Parallel permutation; p beats c2 on c1out from the reset pointer.
    src_q[1].push_back(11'b00000000000);
    src_q[2].push_back(11'b11111111111);
    src_q[0].push_back(11'b01010101010);
    lit_q[0].push_back(11'b00000000000);
    lit_q[1].push_back(11'b01010101010);
    lit_q[1].push_back(11'b11111111111);
    present();
    drain();

    // c1 and p both to c2out; c2out pointer still favours p.
    src_q[1].push_back(11'b11111111111);
    src_q[2].push_back(11'b00000000000);
    src_q[0].push_back(11'b11010101010);
    lit_q[2].push_back(11'b11010101010);
    lit_q[2].push_back(11'b11111111111);
    lit_q[0].push_back(11'b00000000000);
    present();
    drain();

    // Conflict-free three-way permutation.
    src_q[1].push_back(11'b11111100000);
    src_q[2].push_back(11'b00000011111);
    src_q[0].push_back(11'b01010100000);
    lit_q[2].push_back(11'b11111100000);
    lit_q[0].push_back(11'b00000011111);
    lit_q[1].push_back(11'b01010100000);
    present();
    drain();

    // Contention on pout: c2 won last, so c1 goes first.
    src_q[1].push_back(11'b01111111111);
    src_q[2].push_back(11'b00000000000);
    src_q[0].push_back(11'b01010101010);
    lit_q[0].push_back(11'b01111111111);
    lit_q[0].push_back(11'b00000000000);
    lit_q[1].push_back(11'b01010101010);
    present();
    drain();

    // Backpressure on pout while c2out keeps flowing.
    set_sinks(1'b0, 1'b1, 1'b1);
    src_q[1].push_back(11'b00000000000);
    src_q[1].push_back(11'b00000000001);
    src_q[0].push_back(11'b10000000011);
    lit_q[0].push_back(11'b00000000000);
    lit_q[0].push_back(11'b00000000001);
    lit_q[2].push_back(11'b10000000011);
    present();
    repeat (6) step();
    set_sinks(1'b1, 1'b1, 1'b1);
    drain();

    // Reset while all outputs are full: queued words are lost.
    set_sinks(1'b0, 1'b0, 1'b0);
    src_q[0].push_back(11'b00000000111);
    src_q[0].push_back(11'b10000000111);
    src_q[2].push_back(11'b00000001111);
    src_q[1].push_back(11'b10000000000);
    present();
    repeat (3) step();
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) src_q[i].delete();
    present();
    repeat (2) step();
    reset = 1'b0;
    set_sinks(1'b1, 1'b1, 1'b1);
    src_q[2].push_back(11'b10000001111);
    src_q[0].push_back(11'b10000000001);
    lit_q[1].push_back(11'b10000001111);
    lit_q[2].push_back(11'b10000000001);
    present();
    drain();

    // Mixed burst with random words and random sink stalls.
    for (int k = 0; k < 15; k++)
      for (int i = 0; i < 3; i++)
        src_q[i].push_back(11'($urandom_range(0, 2047)));
    present();
    for (int n = 0; n < 1000 && (src_q[0].size() + src_q[1].size() + src_q[2].size()) > 0; n++) begin
      set_sinks(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    set_sinks(1'b1, 1'b1, 1'b1);
    repeat (4) step();

    done = 1'b1;
  end

endmodule
